// File: rtl/alu_regfile.sv
// Operand register file feeding the ALU: two registered read ports, single/pair write-back, flag latch.
// Optional build macro REGFILE_ZERO_REG_EN makes register 0 read as 0x00 and drop writes to it.
module alu_regfile #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_RdEn,
    input  logic [ADDR_W-1:0] i_RdAddr1,
    input  logic [ADDR_W-1:0] i_RdAddr2,
    output logic [DATA_W-1:0] o_Data1,
    output logic [DATA_W-1:0] o_Data2,
    input  logic              i_WrEn,
    input  logic              i_WrPair,
    input  logic [ADDR_W-1:0] i_WrAddr,
    input  logic [DATA_W-1:0] i_WrData,
    input  logic [ADDR_W-1:0] i_WrAddr2,
    input  logic [DATA_W-1:0] i_WrData2,
    input  logic              i_FlagWr,
    input  logic              i_Z,
    input  logic              i_S,
    input  logic              i_C,
    input  logic              i_OF,
    output logic [3:0]        o_Flags,
    output logic              o_Busy,
    output logic              o_DbgState
);

    typedef enum logic {
        IDLE = 1'b0,
        WR2  = 1'b1
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [ADDR_W-1:0] pend_addr_q;
    logic [DATA_W-1:0] pend_data_q;
    logic [DATA_W-1:0] data1_q, data2_q;
    logic [DATA_W-1:0] data1_d, data2_d;
    logic [3:0]        flags_q;
    logic              busy_q;

    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // The single physical write port: new write-back in IDLE, latched second half in WR2.
    always_comb begin
        wr_vld  = 1'b0;
        wr_addr = i_WrAddr;
        wr_data = i_WrData;
        if (state_q == WR2) begin
            wr_vld  = 1'b1;
            wr_addr = pend_addr_q;
            wr_data = pend_data_q;
        end else if (i_WrEn) begin
            wr_vld  = 1'b1;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (wr_addr == '0) begin
            wr_vld = 1'b0;
        end
`endif
    end

    // Operand capture with write-through bypass so a same-edge write is never read stale.
    always_comb begin
        data1_d = regs_q[i_RdAddr1];
        data2_d = regs_q[i_RdAddr2];
        if (wr_vld && (wr_addr == i_RdAddr1)) begin
            data1_d = wr_data;
        end
        if (wr_vld && (wr_addr == i_RdAddr2)) begin
            data2_d = wr_data;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (i_RdAddr1 == '0) begin
            data1_d = '0;
        end
        if (i_RdAddr2 == '0) begin
            data2_d = '0;
        end
`endif
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            flags_q     <= 4'b0000;
        end else begin
            if (wr_vld) begin
                regs_q[wr_addr] <= wr_data;
            end
            if (i_RdEn) begin
                data1_q <= data1_d;
                data2_q <= data2_d;
            end
            if (i_FlagWr) begin
                flags_q <= {i_OF, i_C, i_S, i_Z};
            end
            // Write-back inputs are ignored while the second half of a pair drains.
            case (state_q)
                IDLE: begin
                    if (i_WrEn && i_WrPair) begin
                        state_q     <= WR2;
                        busy_q      <= 1'b1;
                        pend_addr_q <= i_WrAddr2;
                        pend_data_q <= i_WrData2;
                    end
                end
                WR2: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Data1    = data1_q;
    assign o_Data2    = data2_q;
    assign o_Flags    = flags_q;
    assign o_Busy     = busy_q;
    assign o_DbgState = (state_q == WR2);

endmodule

// File: tb/tb_alu_regfile.sv
// Bench for alu_regfile: directed test-plan steps then random traffic, all checked against a queue-based model.
module tb_alu_regfile;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] data1, data2;
    logic          wr_en, wr_pair;
    logic [AW-1:0] wr_addr, wr_addr2;
    logic [DW-1:0] wr_data, wr_data2;
    logic          flag_wr, f_z, f_s, f_c, f_of;
    logic [3:0]    flags;
    logic          busy, dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] mem [NR];
    wr_t           pend_q[$];
    logic [DW-1:0] exp_d1, exp_d2;
    logic [3:0]    exp_flags;
    logic          exp_busy;

    always #5 clk = ~clk;

    alu_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .i_CLK(clk), .i_RST(rst_n),
        .i_RdEn(rd_en), .i_RdAddr1(rd_addr1), .i_RdAddr2(rd_addr2),
        .o_Data1(data1), .o_Data2(data2),
        .i_WrEn(wr_en), .i_WrPair(wr_pair),
        .i_WrAddr(wr_addr), .i_WrData(wr_data),
        .i_WrAddr2(wr_addr2), .i_WrData2(wr_data2),
        .i_FlagWr(flag_wr), .i_Z(f_z), .i_S(f_s), .i_C(f_c), .i_OF(f_of),
        .o_Flags(flags), .o_Busy(busy), .o_DbgState(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic hw, input wr_t w);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        if (hw && w.a == a) return w.d;
        return mem[a];
    endfunction

    // Model: at most one register write per edge; pair second halves wait in a queue.
    task automatic model_step();
        wr_t  w;
        logic hw;
        if (!rst_n) begin
            foreach (mem[i]) mem[i] = '0;
            pend_q.delete();
            exp_d1 = '0; exp_d2 = '0; exp_flags = 4'b0000; exp_busy = 1'b0;
            return;
        end
        hw = 1'b0;
        w  = '0;
        if (pend_q.size() > 0) begin
            w  = pend_q.pop_front();
            hw = 1'b1;
        end else if (wr_en) begin
            w  = '{a: wr_addr, d: wr_data};
            hw = 1'b1;
            if (wr_pair) pend_q.push_back('{a: wr_addr2, d: wr_data2});
        end
`ifdef REGFILE_ZERO_REG_EN
        if (hw && w.a == 0) hw = 1'b0;
`endif
        if (rd_en) begin
            exp_d1 = model_read(rd_addr1, hw, w);
            exp_d2 = model_read(rd_addr2, hw, w);
        end
        if (hw) mem[w.a] = w.d;
        if (flag_wr) exp_flags = {f_of, f_c, f_s, f_z};
        exp_busy = (pend_q.size() != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("data1", data1, exp_d1);
        check("data2", data2, exp_d2);
        check("flags", flags, exp_flags);
        check("busy", busy, exp_busy);
        check("state", dbg_state, exp_busy);
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        wr_en = 1'b0; wr_pair = 1'b0; wr_addr = '0; wr_data = '0;
        wr_addr2 = '0; wr_data2 = '0;
        flag_wr = 1'b0; f_z = 1'b0; f_s = 1'b0; f_c = 1'b0; f_of = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        idle_inputs();
    endtask

    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        idle_inputs();
        rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
        cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        idle_inputs();

        // Reset clears registers, operands, flags and busy
        do_write(3'd3, 8'h5A);
        idle_inputs(); flag_wr = 1'b1; f_c = 1'b1; cycle();
        do_read(3'd3, 3'd3);
        check("pre_reset_r3", data1, 8'h5A);
        idle_inputs(); rst_n = 1'b0; cycle(); idle_inputs();
        check("reset_d1", data1, 8'h00);
        check("reset_d2", data2, 8'h00);
        check("reset_flags", flags, 4'b0000);
        check("reset_busy", busy, 1'b0);
        do_read(3'd3, 3'd3);
        check("reset_r3", data1, 8'h00);

        // Basic read/write
        do_write(3'd1, 8'h12);
        do_write(3'd2, 8'h34);
        do_read(3'd1, 3'd2);
        check("basic_d1", data1, 8'h12);
        check("basic_d2", data2, 8'h34);

        // Write-through bypass on both ports
        do_write(3'd4, 8'h20);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
        rd_en = 1'b1; rd_addr1 = 3'd4; rd_addr2 = 3'd4;
        cycle();
        idle_inputs();
        check("bypass_d1", data1, 8'h77);
        check("bypass_d2", data2, 8'h77);

        // Pair write, busy for exactly one cycle, write during busy ignored
        idle_inputs();
        wr_en = 1'b1; wr_pair = 1'b1;
        wr_addr = 3'd5; wr_data = 8'hAA; wr_addr2 = 3'd6; wr_data2 = 8'hBB;
        cycle();
        check("pair_busy1", busy, 1'b1);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h11;
        rd_en = 1'b1; rd_addr1 = 3'd5; rd_addr2 = 3'd6;
        cycle();
        idle_inputs();
        check("pair_busy2", busy, 1'b0);
        check("pair_wr2_first", data1, 8'hAA);
        check("pair_wr2_bypass", data2, 8'hBB);
        do_read(3'd5, 3'd6);
        check("pair_r5", data1, 8'hAA);
        check("pair_r6", data2, 8'hBB);
        do_read(3'd7, 3'd7);
        check("busy_ignored_r7", data1, 8'h00);

        // Pair with both halves to the same register: second value wins
        idle_inputs();
        wr_en = 1'b1; wr_pair = 1'b1;
        wr_addr = 3'd2; wr_data = 8'hC1; wr_addr2 = 3'd2; wr_data2 = 8'hC2;
        cycle();
        idle_inputs();
        cycle();
        do_read(3'd2, 3'd1);
        check("pair_same_r2", data1, 8'hC2);

        // Reset during WR2 discards the pending half
        do_write(3'd6, 8'h33);
        idle_inputs();
        wr_en = 1'b1; wr_pair = 1'b1;
        wr_addr = 3'd5; wr_data = 8'h01; wr_addr2 = 3'd6; wr_data2 = 8'h02;
        cycle();
        idle_inputs(); rst_n = 1'b0; cycle(); idle_inputs();
        check("midpair_busy", busy, 1'b0);
        check("midpair_state", dbg_state, 1'b0);
        cycle();
        check("midpair_busy_after", busy, 1'b0);
        do_read(3'd5, 3'd6);
        check("midpair_r5", data1, 8'h00);
        check("midpair_r6", data2, 8'h00);

        // Flags, including a flag write accepted while busy
        idle_inputs();
        flag_wr = 1'b1; f_z = 1'b1; f_s = 1'b0; f_c = 1'b1; f_of = 1'b0;
        cycle();
        idle_inputs();
        check("flags_0101", flags, 4'b0101);
        wr_en = 1'b1; wr_pair = 1'b1; wr_addr = 3'd1; wr_addr2 = 3'd3;
        cycle();
        idle_inputs();
        flag_wr = 1'b1; f_of = 1'b1; f_s = 1'b1;
        cycle();
        idle_inputs();
        check("flags_in_wr2", flags, 4'b1010);

        // Register 0
        do_write(3'd0, 8'hFF);
        do_read(3'd0, 3'd0);
`ifdef REGFILE_ZERO_REG_EN
        check("zero_reg", data1, 8'h00);
`else
        check("r0_ordinary", data1, 8'hFF);
`endif

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            rd_en    = $urandom_range(0, 1);
            rd_addr1 = AW'($urandom_range(0, NR - 1));
            rd_addr2 = AW'($urandom_range(0, NR - 1));
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_pair  = ($urandom_range(0, 3) == 0);
            wr_addr  = AW'($urandom_range(0, NR - 1));
            wr_addr2 = AW'($urandom_range(0, NR - 1));
            wr_data  = DW'($urandom);
            wr_data2 = DW'($urandom);
            flag_wr  = $urandom_range(0, 1);
            f_z = $urandom_range(0, 1); f_s = $urandom_range(0, 1);
            f_c = $urandom_range(0, 1); f_of = $urandom_range(0, 1);
            cycle();
        end
        idle_inputs();
        cycle();

        // Final sweep of every register
        for (int a = 0; a < NR; a++) begin
            do_read(AW'(a), AW'(NR - 1 - a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
